// File: rtl/systolic_pkg.sv
// systolic_pkg: shared types and helpers for the N x N systolic matrix multiplier.
//   state_e : controller states (IDLE, CLEAR, RUN, DONE)
//   step_w  : width of the RUN step counter for a given matrix dimension
//   rm_idx  : row-major flat element index
package systolic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Counter must reach 3N-3; $clog2(3N) bits always cover it.
    function automatic int unsigned step_w(input int unsigned n);
        return $clog2(3 * n);
    endfunction

    function automatic int unsigned rm_idx(input int unsigned r,
                                           input int unsigned c,
                                           input int unsigned n);
        return r * n + c;
    endfunction

endpackage

// File: rtl/systolic_mm_nxn_if.sv
// systolic_mm_nxn_if: job handshake and matrix buses of the systolic multiplier.
//   start_i       : start request (caller -> multiplier)
//   a_i, b_i      : flattened row-major operand matrices
//   busy_o        : job in progress (CLEAR/RUN)
//   done_o        : one-cycle completion pulse
//   res_o         : flattened row-major result matrix
// Modports: master = caller, slave = multiplier.
interface systolic_mm_nxn_if #(
    parameter int unsigned N          = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ACC_WIDTH  = 2 * DATA_WIDTH + $clog2(N)
);

    logic                          start_i;
    logic [N*N*DATA_WIDTH-1:0]     a_i;
    logic [N*N*DATA_WIDTH-1:0]     b_i;
    logic                          busy_o;
    logic                          done_o;
    logic [N*N*ACC_WIDTH-1:0]      res_o;

    modport master (output start_i, a_i, b_i, input busy_o, done_o, res_o);
    modport slave  (input start_i, a_i, b_i, output busy_o, done_o, res_o);

endinterface

// File: rtl/systolic_pe.sv
// systolic_pe: one multiply-accumulate cell of the output-stationary array.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   clr_i         : synchronous clear of accumulator and pass registers
//   en_i          : accumulate and shift enable
//   a_i, b_i      : operands from the west / north neighbour
//   a_o, b_o      : registered operands to the east / south neighbour
//   acc_nxt_c     : combinational next accumulator value (acc + a_i*b_i)
// Build option: SYSTOLIC_SIGNED_EN selects two's-complement arithmetic.
module systolic_pe #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ACC_WIDTH  = 66
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clr_i,
    input  logic                  en_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic [DATA_WIDTH-1:0] a_o,
    output logic [DATA_WIDTH-1:0] b_o,
    output logic [ACC_WIDTH-1:0]  acc_nxt_c
);

    localparam int unsigned PROD_W = 2 * DATA_WIDTH;

    logic [ACC_WIDTH-1:0] acc_q;

`ifdef SYSTOLIC_SIGNED_EN
    // Signed size-casts sign-extend, so both the product and its extension are signed.
    logic signed [PROD_W-1:0] prod;
    assign prod      = PROD_W'($signed(a_i)) * PROD_W'($signed(b_i));
    assign acc_nxt_c = acc_q + ACC_WIDTH'(prod);
`else
    logic [PROD_W-1:0] prod;
    assign prod      = PROD_W'(a_i) * PROD_W'(b_i);
    assign acc_nxt_c = acc_q + ACC_WIDTH'(prod);
`endif

    // Accumulator and operand pass-through registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || clr_i) begin
            acc_q <= '0;
            a_o   <= '0;
            b_o   <= '0;
        end else if (en_i) begin
            acc_q <= acc_nxt_c;
            a_o   <= a_i;
            b_o   <= b_i;
        end
    end

endmodule

// File: rtl/systolic_mm_nxn.sv
// systolic_mm_nxn: N x N output-stationary systolic multiplier, C = A * B.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   bus (slave)   : start_i, a_i, b_i in; busy_o, done_o, res_o out
// Operands are latched at start, skewed internally onto the array edges and
// streamed for 3N-2 RUN steps; the result bank is loaded on entry to DONE.
// Latency from the start cycle to done_o is 3N cycles.
// Build option: SYSTOLIC_SIGNED_EN selects two's-complement arithmetic.
module systolic_mm_nxn
    import systolic_pkg::*;
#(
    parameter int unsigned N          = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ACC_WIDTH  = 2 * DATA_WIDTH + $clog2(N)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    systolic_mm_nxn_if.slave   bus
);

    localparam int unsigned STEP_W = step_w(N);
    localparam int unsigned LAST_K = 3 * N - 3;
    localparam int unsigned MAT_W  = N * N * DATA_WIDTH;
    localparam int unsigned RES_W  = N * N * ACC_WIDTH;

    state_e                state_q;
    logic [STEP_W-1:0]     k_q;
    logic [MAT_W-1:0]      a_q;
    logic [MAT_W-1:0]      b_q;
    logic                  busy_q;
    logic                  done_q;
    logic [RES_W-1:0]      res_q;

    logic                  pe_clr;
    logic                  pe_en;
    int                    k_int;
    logic [DATA_WIDTH-1:0] a_edge [N];
    logic [DATA_WIDTH-1:0] b_edge [N];
    logic [DATA_WIDTH-1:0] a_pipe [N][N];
    logic [DATA_WIDTH-1:0] b_pipe [N][N];
    logic [ACC_WIDTH-1:0]  acc_nxt [N][N];
    logic [RES_W-1:0]      acc_flat;
    logic                  unused_tail;

    assign pe_clr = (state_q == ST_CLEAR);
    assign pe_en  = (state_q == ST_RUN);
    assign k_int  = int'(k_q);

    // Edge skew: row r sees A[r][k-r], column c sees B[k-c][c], zero outside the band.
    always_comb begin
        for (int r = 0; r < int'(N); r++) begin
            a_edge[r] = '0;
            b_edge[r] = '0;
            if (k_int >= r && k_int - r < int'(N)) begin
                a_edge[r] = a_q[rm_idx(r, k_int - r, N) * DATA_WIDTH +: DATA_WIDTH];
                b_edge[r] = b_q[rm_idx(k_int - r, r, N) * DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // PE grid: A flows east, B flows south.
    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            logic [DATA_WIDTH-1:0] a_in;
            logic [DATA_WIDTH-1:0] b_in;

            if (j == 0) begin : g_a_edge
                assign a_in = a_edge[i];
            end else begin : g_a_pipe
                assign a_in = a_pipe[i][j-1];
            end

            if (i == 0) begin : g_b_edge
                assign b_in = b_edge[j];
            end else begin : g_b_pipe
                assign b_in = b_pipe[i-1][j];
            end

            systolic_pe #(
                .DATA_WIDTH (DATA_WIDTH),
                .ACC_WIDTH  (ACC_WIDTH)
            ) u_pe (
                .clk_i     (clk_i),
                .rst_ni    (rst_ni),
                .clr_i     (pe_clr),
                .en_i      (pe_en),
                .a_i       (a_in),
                .b_i       (b_in),
                .a_o       (a_pipe[i][j]),
                .b_o       (b_pipe[i][j]),
                .acc_nxt_c (acc_nxt[i][j])
            );
        end
    end

    // Operands leaving the east/south edges have no consumer.
    always_comb begin
        unused_tail = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            unused_tail = unused_tail ^ (^a_pipe[i][N-1]) ^ (^b_pipe[N-1][i]);
        end
    end

    // The result bank takes the post-update accumulators of the final step.
    always_comb begin
        acc_flat = '0;
        for (int i = 0; i < int'(N); i++) begin
            for (int j = 0; j < int'(N); j++) begin
                acc_flat[rm_idx(i, j, N) * ACC_WIDTH +: ACC_WIDTH] = acc_nxt[i][j];
            end
        end
    end

    // Controller with registered handshake outputs and result bank.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            res_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (bus.start_i) begin
                        a_q     <= bus.a_i;
                        b_q     <= bus.b_i;
                        busy_q  <= 1'b1;
                        state_q <= ST_CLEAR;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_CLEAR: begin
                    k_q     <= '0;
                    res_q   <= '0;
                    state_q <= ST_RUN;
                end
                ST_RUN: begin
                    if (k_q == STEP_W'(LAST_K)) begin
                        res_q   <= acc_flat;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_DONE;
                    end else begin
                        k_q <= k_q + STEP_W'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy_o = busy_q;
    assign bus.done_o = done_q;
    assign bus.res_o  = res_q;

endmodule

// File: tb/tb_systolic_mm_nxn.sv
// tb_systolic_mm_nxn: directed vector table plus hand-written multi-cycle
// sequences (held start / back-to-back, reset mid-run, streamed random jobs)
// for the 4x4, 32-bit systolic multiplier.
module tb_systolic_mm_nxn;

    localparam int unsigned N   = 4;
    localparam int unsigned DW  = 32;
    localparam int unsigned AW  = 66;
    localparam int unsigned EL  = N * N;
    localparam int          LAT = 3 * N;
    localparam int          NRND = 10;

    typedef logic [EL*DW-1:0] mat_t;
    typedef logic [EL*AW-1:0] res_t;
    typedef struct {
        mat_t a;
        mat_t b;
        res_t exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_ni;
    int   n_cmp = 0;
    int   n_err = 0;

    vec_t vecs [4];
    mat_t ra [NRND];
    mat_t rb [NRND];

    always #5 clk = ~clk;

    systolic_mm_nxn_if #(.N(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW)) bus ();

    systolic_mm_nxn #(.N(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW)) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    function automatic mat_t set_m(input mat_t m, input int r, input int c, input logic [DW-1:0] v);
        m[(r*N+c)*DW +: DW] = v;
        return m;
    endfunction

    function automatic res_t set_r(input res_t m, input int r, input int c, input logic [AW-1:0] v);
        m[(r*N+c)*AW +: AW] = v;
        return m;
    endfunction

    function automatic mat_t rnd_mat(input logic [DW-1:0] mask);
        mat_t m;
        for (int e = 0; e < int'(EL); e++) m[e*DW +: DW] = $urandom() & mask;
        return m;
    endfunction

    // Plain textbook matrix product used for the random jobs.
    function automatic res_t ref_mm(input mat_t a, input mat_t b);
        res_t        r;
        logic [AW-1:0] s;
        r = '0;
        for (int i = 0; i < int'(N); i++) begin
            for (int j = 0; j < int'(N); j++) begin
                s = '0;
                for (int k = 0; k < int'(N); k++)
                    s = s + AW'(a[(i*N+k)*DW +: DW]) * AW'(b[(k*N+j)*DW +: DW]);
                r[(i*N+j)*AW +: AW] = s;
            end
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic chk_res(input string name, input res_t exp);
        int            first;
        logic [AW-1:0] g;
        logic [AW-1:0] x;
        n_cmp++;
        if (bus.res_o !== exp) begin
            n_err++;
            first = 0;
            for (int e = int'(EL) - 1; e >= 0; e--)
                if (bus.res_o[e*AW +: AW] !== exp[e*AW +: AW]) first = e;
            g = bus.res_o[first*AW +: AW];
            x = exp[first*AW +: AW];
            $display("FAIL %s: element %0d got %h, expected %h", name, first, g, x);
        end
    endtask

    // One job from a single start pulse; operands scrambled right after the start edge.
    task automatic run_job(input string name, input mat_t a, input mat_t b, input res_t exp);
        int done_cyc;
        int bad;
        done_cyc = -1;
        bad      = 0;
        @(negedge clk);
        bus.a_i     = a;
        bus.b_i     = b;
        bus.start_i = 1'b1;
        for (int cyc = 1; cyc <= LAT + 3; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                bus.start_i = 1'b0;
                bus.a_i     = rnd_mat('1);
                bus.b_i     = rnd_mat('1);
            end
            if (bus.done_o === 1'b1 && done_cyc < 0) done_cyc = cyc;
            if (bus.busy_o !== (cyc < LAT)) bad++;
            if (bus.done_o !== (cyc == LAT)) bad++;
            if (cyc == LAT) chk_res({name, " result"}, exp);
        end
        chk({name, " latency"}, 64'(done_cyc), 64'(LAT));
        chk({name, " busy/done profile errors"}, 64'(bad), 64'd0);
        chk_res({name, " result held"}, exp);
    endtask

    initial begin
        int   dones [$];
        int   j;
        int   bad;

        rst_ni      = 1'b0;
        bus.start_i = 1'b0;
        bus.a_i     = '0;
        bus.b_i     = '0;

        // Directed vectors with hand-computed results.
        for (int v = 0; v < 4; v++) begin
            vecs[v].a   = '0;
            vecs[v].b   = '0;
            vecs[v].exp = '0;
        end
        // v0: identity * B, B[r][c] = 4r+c  ->  B
        for (int r = 0; r < int'(N); r++) begin
            vecs[0].a = set_m(vecs[0].a, r, r, 32'd1);
            for (int c = 0; c < int'(N); c++) begin
                vecs[0].b   = set_m(vecs[0].b, r, c, DW'(4*r + c));
                vecs[0].exp = set_r(vecs[0].exp, r, c, AW'(4*r + c));
            end
        end
        // v1: all ones -> 4*(2^32-1)^2 unsigned, 4 as two's complement
        vecs[1].a = '1;
        vecs[1].b = '1;
        for (int e = 0; e < int'(EL); e++)
`ifdef SYSTOLIC_SIGNED_EN
            vecs[1].exp[e*AW +: AW] = 66'd4;
`else
            vecs[1].exp[e*AW +: AW] = 66'h3_FFFF_FFF8_0000_0004;
`endif
        // v2: A all 1, B[r][c] = 4r+c  ->  C[i][j] = 24 + 4j
        vecs[2].a = rnd_mat('0);
        for (int e = 0; e < int'(EL); e++) vecs[2].a[e*DW +: DW] = 32'd1;
        for (int r = 0; r < int'(N); r++)
            for (int c = 0; c < int'(N); c++) begin
                vecs[2].b   = set_m(vecs[2].b, r, c, DW'(4*r + c));
                vecs[2].exp = set_r(vecs[2].exp, r, c, AW'(24 + 4*c));
            end
        // v3: 2x2 block in the upper-left corner, rest zero
`ifdef SYSTOLIC_SIGNED_EN
        vecs[3].a   = set_m(set_m(set_m(set_m(vecs[3].a, 0, 0, -DW'(1)), 0, 1, DW'(2)), 1, 0, DW'(3)), 1, 1, -DW'(4));
        vecs[3].b   = set_m(set_m(set_m(set_m(vecs[3].b, 0, 0, DW'(5)), 0, 1, -DW'(6)), 1, 0, -DW'(7)), 1, 1, DW'(8));
        vecs[3].exp = set_r(set_r(set_r(set_r(vecs[3].exp, 0, 0, -AW'(19)), 0, 1, AW'(22)), 1, 0, AW'(43)), 1, 1, -AW'(50));
`else
        vecs[3].a   = set_m(set_m(set_m(set_m(vecs[3].a, 0, 0, DW'(1)), 0, 1, DW'(2)), 1, 0, DW'(3)), 1, 1, DW'(4));
        vecs[3].b   = set_m(set_m(set_m(set_m(vecs[3].b, 0, 0, DW'(5)), 0, 1, DW'(6)), 1, 0, DW'(7)), 1, 1, DW'(8));
        vecs[3].exp = set_r(set_r(set_r(set_r(vecs[3].exp, 0, 0, AW'(19)), 0, 1, AW'(22)), 1, 0, AW'(43)), 1, 1, AW'(50));
`endif

        // Reset state.
        repeat (3) @(negedge clk);
        chk("reset busy_o", 64'(bus.busy_o), 64'd0);
        chk("reset done_o", 64'(bus.done_o), 64'd0);
        chk_res("reset res_o", '0);
        rst_ni = 1'b1;

        for (int v = 0; v < 4; v++) run_job($sformatf("vec%0d", v), vecs[v].a, vecs[v].b, vecs[v].exp);

        // Start held high; a_i/b_i change during RUN. The DONE cycle starts job 2.
        @(negedge clk);
        bus.a_i     = vecs[0].a;
        bus.b_i     = vecs[0].b;
        bus.start_i = 1'b1;
        bad = 0;
        for (int cyc = 1; cyc <= 2 * LAT + 3; cyc++) begin
            @(negedge clk);
            if (cyc == 2) begin
                bus.a_i = vecs[2].a;
                bus.b_i = vecs[2].b;
            end
            if (bus.done_o === 1'b1) dones.push_back(cyc);
            if (cyc == LAT) chk_res("held-start job1 result", vecs[0].exp);
            if (cyc == 2 * LAT) begin
                chk_res("held-start job2 result", vecs[2].exp);
                bus.start_i = 1'b0;
            end
            if (cyc == LAT + 1 && bus.busy_o !== 1'b1) bad++;
        end
        chk("held-start done count", 64'(dones.size()), 64'd2);
        if (dones.size() == 2) begin
            chk("held-start done1 cycle", 64'(dones[0]), 64'(LAT));
            chk("held-start done2 cycle", 64'(dones[1]), 64'(2 * LAT));
        end
        chk("held-start busy after back-to-back start", 64'(bad), 64'd0);
        chk("held-start idle busy_o", 64'(bus.busy_o), 64'd0);

        // Reset during RUN step 5 (cycle 7) discards the job.
        @(negedge clk);
        bus.a_i     = vecs[2].a;
        bus.b_i     = vecs[2].b;
        bus.start_i = 1'b1;
        for (int cyc = 1; cyc <= 7; cyc++) begin
            @(negedge clk);
            if (cyc == 1) bus.start_i = 1'b0;
        end
        chk("pre-reset busy_o", 64'(bus.busy_o), 64'd1);
        rst_ni = 1'b0;
        @(negedge clk);
        chk("mid-run reset busy_o", 64'(bus.busy_o), 64'd0);
        chk("mid-run reset done_o", 64'(bus.done_o), 64'd0);
        chk_res("mid-run reset res_o", '0);
        @(negedge clk);
        rst_ni = 1'b1;
        bad = 0;
        repeat (LAT + 2) begin
            @(negedge clk);
            if (bus.done_o !== 1'b0 || bus.busy_o !== 1'b0) bad++;
        end
        chk("no done/busy after discarded job", 64'(bad), 64'd0);
        run_job("after-reset vec3", vecs[3].a, vecs[3].b, vecs[3].exp);

        // Streamed random 8-bit jobs, next operands presented in each DONE cycle.
        for (int n = 0; n < NRND; n++) begin
            ra[n] = rnd_mat(32'hFF);
            rb[n] = rnd_mat(32'hFF);
        end
        @(negedge clk);
        bus.a_i     = ra[0];
        bus.b_i     = rb[0];
        bus.start_i = 1'b1;
        j = 0;
        for (int cyc = 1; cyc <= NRND * LAT + 4; cyc++) begin
            @(negedge clk);
            if (bus.done_o === 1'b1) begin
                if (j < NRND) begin
                    chk_res($sformatf("stream job%0d result", j), ref_mm(ra[j], rb[j]));
                    chk($sformatf("stream job%0d done cycle", j), 64'(cyc), 64'((j + 1) * LAT));
                end
                j++;
                if (j < NRND) begin
                    bus.a_i = ra[j];
                    bus.b_i = rb[j];
                end else begin
                    bus.start_i = 1'b0;
                end
            end else if (cyc % LAT == 1) begin
                bus.a_i = rnd_mat('1);
                bus.b_i = rnd_mat('1);
            end
        end
        chk("stream done count", 64'(j), 64'(NRND));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/systolic_mm_nxn.md
# systolic_mm_nxn

Parametrised N×N output-stationary systolic matrix multiplier with start/done handshake, internal operand skewing and a registered result bank. It computes C = A·B for square matrices presented as flattened buses. It replaces the fixed 4×4 array, whose caller had to pre-skew operands and whose free-running counter gave no per-job handshake. It sits between the operand register file and the result write-back logic.

## Interface
- `N`, default 4: matrix dimension, 2..16.
- `DATA_WIDTH`, default 32: operand width.
- `ACC_WIDTH`, default `2*DATA_WIDTH+$clog2(N)`: accumulator/result width; must be ≥ `2*DATA_WIDTH`.
- `clk_i` input, 1 bit: the single clock; all logic is on its rising edge.
- `rst_ni` input, 1 bit: reset, synchronous and active-low.
- `start_i` input, 1 bit: start request; sampled only in IDLE or DONE.
- `a_i` input, `N*N*DATA_WIDTH` bits: matrix A, row-major; element [r][c] at slice index r*N+c.
- `b_i` input, `N*N*DATA_WIDTH` bits: matrix B, same layout.
- `busy_o` output, 1 bit: high in CLEAR and RUN.
- `done_o` output, 1 bit: one-cycle pulse in DONE.
- `res_o` output, `N*N*ACC_WIDTH` bits: matrix C, row-major; holds its value until the next CLEAR.

## Operation
- FSM states: IDLE → CLEAR → RUN → DONE → IDLE.
- IDLE, `start_i`=1:
  - latch `a_i` and `b_i` into internal operand registers;
  - go to CLEAR.
- CLEAR (1 cycle): zero every PE accumulator and pass register, and zero the step counter `k`.
- RUN (3N−2 cycles, k = 0..3N−3):
  - row edge r drives A[r][k−r] when 0 ≤ k−r < N, otherwise 0;
  - column edge c drives B[k−c][c] when 0 ≤ k−c < N, otherwise 0.
- PE(i,j) each RUN cycle:
  - acc ← acc + a_in·b_in;
  - a_out ← a_in;
  - b_out ← b_in.
- Alignment: PE(i,j) receives A[i][k] and B[k][j] together at step k+i+j, so the last product (PE(N−1,N−1), k=N−1) lands at step 3N−3.
- DONE (1 cycle):
  - `done_o`=1;
  - `res_o` is valid and is a copy of the accumulators, registered on entry to DONE.
  - `start_i`=1 here goes directly to CLEAR with new operands (back-to-back). Otherwise go to IDLE.
- `start_i` during CLEAR or RUN is ignored. Operands are not re-sampled.
- `a_i` and `b_i` may change freely after the start cycle.
- Arithmetic:
  - unsigned by default;
  - product width is 2·DATA_WIDTH, zero-extended to ACC_WIDTH;
  - accumulation wraps modulo 2^ACC_WIDTH. With the default ACC_WIDTH, overflow cannot occur.
- Reset (any state, `rst_ni`=0 at an edge):
  - FSM → IDLE;
  - `busy_o`, `done_o`, `res_o`, accumulators, operand registers and counter all go to 0;
  - a job in flight is discarded with no `done_o`.

## Timing
- Cycle 0: `start_i` sampled high.
- Cycle 1: CLEAR.
- Cycles 2..3N−1: RUN.
- Cycle 3N: `done_o`=1 and `res_o` valid. Latency is 3N cycles (12 for N=4).
- `busy_o`=1 in cycles 1..3N−1.
- Back-to-back throughput: one job per 3N cycles.
- All outputs are registered. No combinational path from inputs to outputs.

## Configuration
- `SYSTOLIC_SIGNED_EN` defined:
  - operands are two's-complement;
  - products are signed;
  - accumulators sign-extend to ACC_WIDTH;
  - `res_o` is signed.
- Undefined: all arithmetic is unsigned, as described above.
- Latency, handshake and FSM are identical in both builds.

## Structure
- Shared package `systolic_pkg` holds:
  - FSM state enum (IDLE, CLEAR, RUN, DONE);
  - `STEP_W = $clog2(3N)` counter-width function;
  - row-major index helper.
- One sub-module, `systolic_pe`:
  - multiply-accumulate;
  - registered a/b pass-through;
  - synchronous clear;
  - enable.
- The top level generates the N×N PE grid, edge feeders, FSM and result register.

## Test plan
- N=4, A=identity, B[r][c]=r*4+c, start pulse → `done_o` at cycle 12, `res_o`=B, `busy_o` high in cycles 1..11.
- N=4, A and B all 0xFFFFFFFF (unsigned build) → every C element = 4·(2^32−1)^2 = 0x3_FFFF_FFF8_0000_0004, with no truncation in ACC_WIDTH=66.
- `SYSTOLIC_SIGNED_EN`, N=2, A=[[−1,2],[3,−4]], B=[[5,−6],[−7,8]] → C=[[−19,22],[43,−50]].
- `start_i` held high through RUN with different `a_i` → first result unaffected. Second job starts from the DONE cycle, and its `done_o` comes 3N cycles later.
- `rst_ni` low at RUN step 5 → next cycle all outputs 0 and state IDLE. No `done_o`. A new start then gives correct results.
- N=3 build, random 8-bit operands, 50 back-to-back jobs → each `res_o` matches the reference model, one `done_o` per job, spaced 9 cycles apart.
